// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared state encodings and widths for the seq_scan arbiter and detector.
package seq_scan_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} ctrl_state_t;
  typedef enum logic [2:0] {START, Z1, Z2, Z2O1, FOUND} det_state_t;
  localparam int TOT_W = 16;
endpackage

// File: rtl/seq_scan_det.sv
// seq_scan_det: Moore "0011" detector, MSB-first serial input, with sync restart.
module seq_scan_det
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic en,
  input  logic in,
  output logic match
);
  det_state_t state_q, state_d;
  always_comb begin
    state_d = state_q;
    if (start) state_d = START;
    else if (en)
      case (state_q)
        START:   state_d = in ? START : Z1;
        Z1:      state_d = in ? START : Z2;
        Z2:      state_d = in ? Z2O1  : Z2;
        Z2O1:    state_d = in ? FOUND : Z1;
        FOUND:   state_d = in ? START : Z1;
        default: state_d = START;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!clr) state_q <= START;
    else state_q <= state_d;
  end
  assign match = state_q == FOUND;
endmodule

// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: round-robin two-requester front end feeding one serial "0011" detector.
// Optional SEQ_SCAN_TOTAL_EN adds a saturating running total of matches (total_cnt).
module seq_scan_arbiter
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [1:0]        req,
  input  logic [WORD_W-1:0] data0,
  input  logic [WORD_W-1:0] data1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              match_any
`ifdef SEQ_SCAN_TOTAL_EN
  ,
  output logic [TOT_W-1:0]  total_cnt
`endif
);
  localparam int BW = $clog2(WORD_W);
  ctrl_state_t state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] work_q, work_d, cnt_q, cnt_d, work_inc;
  logic id_q, id_d, rid_q, rid_d, last_q, last_d;
  logic match, det_start, det_en;
  always_comb begin
    gnt = 2'b00;
    if (state_q == IDLE && clr) gnt = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
    work_inc = (match && work_q != '1) ? work_q + 1'b1 : work_q;
    state_d = state_q;
    sh_d = sh_q;
    bit_d = bit_q;
    work_d = work_q;
    cnt_d = cnt_q;
    id_d = id_q;
    rid_d = rid_q;
    last_d = last_q;
    det_start = 1'b0;
    det_en = 1'b0;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = SHIFT;
        sh_d = gnt[1] ? data1 : data0;
        id_d = gnt[1];
        last_d = gnt[1];
        bit_d = '0;
        work_d = '0;
        det_start = 1'b1;
      end
      SHIFT: begin
        det_en = 1'b1;
        sh_d = sh_q << 1;
        bit_d = bit_q + 1'b1;
        work_d = work_inc;
        if (bit_q == BW'(WORD_W - 1)) state_d = FLUSH;
      end
      // Results load here so they are already valid while done is high.
      FLUSH: begin
        work_d = work_inc;
        cnt_d = work_inc;
        rid_d = id_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      sh_q <= '0;
      bit_q <= '0;
      work_q <= '0;
      cnt_q <= '0;
      id_q <= 1'b0;
      rid_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      work_q <= work_d;
      cnt_q <= cnt_d;
      id_q <= id_d;
      rid_q <= rid_d;
      last_q <= last_d;
    end
  end
  seq_scan_det u_det (
    .clk  (clk),
    .clr  (clr),
    .start(det_start),
    .en   (det_en),
    .in   (sh_q[WORD_W-1]),
    .match(match)
  );
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign done_id = rid_q;
  assign match_cnt = cnt_q;
  assign match_any = |cnt_q;
`ifdef SEQ_SCAN_TOTAL_EN
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [TOT_W:0] tot_sum;
  always_comb begin
    tot_sum = {1'b0, tot_q} + {{(TOT_W + 1 - CNT_W){1'b0}}, work_inc};
    tot_d = (state_q == FLUSH) ? (tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0]) : tot_q;
  end
  always_ff @(posedge clk) begin
    if (!clr) tot_q <= '0;
    else tot_q <= tot_d;
  end
  assign total_cnt = tot_q;
`endif
endmodule
